// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Used by mem_arbiter and arb_pick2.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_pick2.sv
// Two-way request picker, one-hot grant (bit 0 IFU, bit 1 LSU).
// ARB_RR_EN: round-robin pointer; otherwise fixed LSU > IFU.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

`ifdef ARB_RR_EN
    logic ptr;

    // Point at the master that was not just granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= MST_LSU;
        end else if (upd) begin
            ptr <= gnt[MST_IFU] ? MST_LSU : MST_IFU;
        end
    end

    // Lone requester wins; on conflict the favoured master wins
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = (ptr == MST_LSU) ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused;
    assign unused = ^{clk, rst, upd};

    // Fixed priority, LSU ahead of IFU
    always_comb begin
        gnt = req;
        if (req[MST_LSU]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter for the single data-memory port, one txn in flight.
// Optional ARB_RR_EN selects round-robin instead of LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [7:0]        lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_req_addr,
    output logic              s_req_wen,
    output logic [DATA_W-1:0] s_req_wdata,
    output logic [7:0]        s_req_wmask,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [DATA_W-1:0] s_resp_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_inc;
    logic              expired;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              req_hs;

    assign req    = {lsu_req_valid, ifu_req_valid};
    assign req_hs = (state_q == IDLE) && (|req);

    // The RESP cycle that would bring the count to TIMEOUT is the last
    assign cnt_inc = cnt_q + CW'(1);
    assign expired = (cnt_inc == CW'(TIMEOUT));

    arb_pick2 u_pick (
        .clk (clk),
        .rst (rst),
        .req (req),
        .upd (req_hs),
        .gnt (gnt)
    );

    assign s_req_addr  = addr_q;
    assign s_req_wen   = wen_q;
    assign s_req_wdata = wdata_q;
    assign s_req_wmask = wmask_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d        = state_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        s_req_valid    = 1'b0;
        s_resp_ready   = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                ifu_req_ready = rst & gnt[MST_IFU];
                lsu_req_ready = rst & gnt[MST_LSU];
                if (|req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                s_req_valid = 1'b1;
                if (s_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                s_resp_ready = 1'b1;
                if (s_resp_valid || expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ifu_resp_valid = (grant_q == MST_IFU);
                lsu_resp_valid = (grant_q == MST_LSU);
                if (grant_q == MST_LSU ? lsu_resp_ready : ifu_resp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Request latch, response latch and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= MST_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (req_hs) begin
                grant_q <= gnt[MST_LSU];
                if (gnt[MST_LSU]) begin
                    addr_q  <= lsu_req_addr;
                    wen_q   <= lsu_req_wen;
                    wdata_q <= lsu_req_wdata;
                    wmask_q <= lsu_req_wmask;
                end else begin
                    addr_q  <= ifu_req_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= 8'h00;
                end
            end
            if (state_q == REQ && s_req_ready) begin
                cnt_q <= '0;
            end
            if (state_q == RESP) begin
                if (s_resp_valid) begin
                    rdata_q <= s_resp_rdata;
                    err_q   <= 1'b0;
                end else if (expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
// Build with +define+ARB_RR_EN to exercise the round-robin picker.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready = 1'b0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr = '0;
    logic        lsu_req_wen = 1'b0;
    logic [31:0] lsu_req_wdata = '0;
    logic [7:0]  lsu_req_wmask = '0;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        s_req_valid;
    logic        s_req_ready = 1'b0;
    logic [31:0] s_req_addr;
    logic        s_req_wen;
    logic [31:0] s_req_wdata;
    logic [7:0]  s_req_wmask;
    logic        s_resp_valid = 1'b0;
    logic        s_resp_ready;
    logic [31:0] s_resp_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_ready(ifu_resp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr), .s_req_wen(s_req_wen),
        .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_rdata(s_resp_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one transaction record plus its phase
    // phase 0 waiting for a request, 1 offered to slave,
    // 2 awaiting slave reply, 3 delivering to master
    typedef struct packed {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    int          m_ph = 0;
    int          m_wait = 0;
    txn_t        m_cur = '0;
    logic        m_ptr = 1'b1;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    function automatic logic pick_lsu(input logic iv, input logic lv);
        if (iv && lv) begin
`ifdef ARB_RR_EN
            return m_ptr;
`else
            return 1'b1;
`endif
        end
        return lv;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= 0;
            m_wait <= 0;
            m_cur <= '0;
            m_ptr <= 1'b1;
            m_rdata <= '0;
            m_err <= 1'b0;
        end else begin
            case (m_ph)
                0: if (ifu_req_valid || lsu_req_valid) begin
                    if (pick_lsu(ifu_req_valid, lsu_req_valid)) begin
                        m_cur <= '{1'b1, lsu_req_addr, lsu_req_wen,
                                   lsu_req_wdata, lsu_req_wmask};
                        m_ptr <= 1'b0;
                    end else begin
                        m_cur <= '{1'b0, ifu_req_addr, 1'b0, 32'h0, 8'h00};
                        m_ptr <= 1'b1;
                    end
                    m_ph <= 1;
                end
                1: if (s_req_ready) begin
                    m_ph <= 2;
                    m_wait <= 0;
                end
                2: begin
                    m_wait <= m_wait + 1;
                    if (s_resp_valid) begin
                        m_rdata <= s_resp_rdata;
                        m_err <= 1'b0;
                        m_ph <= 3;
                    end else if (m_wait + 1 == TO) begin
                        m_rdata <= '0;
                        m_err <= 1'b1;
                        m_ph <= 3;
                    end
                end
                default: if (m_cur.lsu ? lsu_resp_ready : ifu_resp_ready) m_ph <= 0;
            endcase
        end
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin : cmp
        logic pl;
        logic any;
        pl  = pick_lsu(ifu_req_valid, lsu_req_valid);
        any = rst && m_ph == 0 && (ifu_req_valid || lsu_req_valid);
        chk("m_ifu_req_ready", ifu_req_ready, any && !pl);
        chk("m_lsu_req_ready", lsu_req_ready, any && pl);
        chk("m_s_req_valid", s_req_valid, m_ph == 1);
        chk("m_s_resp_ready", s_resp_ready, m_ph == 2);
        chk("m_ifu_resp_valid", ifu_resp_valid, m_ph == 3 && !m_cur.lsu);
        chk("m_lsu_resp_valid", lsu_resp_valid, m_ph == 3 && m_cur.lsu);
        if (m_ph == 1) begin
            chk("m_s_req_addr", s_req_addr, m_cur.addr);
            chk("m_s_req_wen", s_req_wen, m_cur.wen);
            chk("m_s_req_wmask", s_req_wmask, m_cur.wmask);
            if (m_cur.wen) chk("m_s_req_wdata", s_req_wdata, m_cur.wdata);
        end
        if (m_ph == 3) begin
            chk("m_resp_rdata", resp_rdata, m_rdata);
            chk("m_resp_err", resp_err, m_err);
        end
    end

    // Drive a granted request (now in REQ) to completion with a fast slave
    task automatic complete(input string nm, input logic who, input logic [31:0] rd);
        int n;
        n = 0;
        s_req_ready = 1'b1;
        s_resp_valid = 1'b1;
        s_resp_rdata = rd;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        while (!(ifu_resp_valid || lsu_resp_valid) && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, n < 20, 1'b1);
        chk({nm, "_who"}, lsu_resp_valid, who);
        chk({nm, "_rdata"}, resp_rdata, rd);
        s_req_ready = 1'b0;
        s_resp_valid = 1'b0;
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic [2:0] exp3;

        // Reset state
        repeat (3) tick();
        chk("rst_s_req_valid", s_req_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_s_req_addr", s_req_addr, 0);
        rst = 1'b1;
        tick();

        // 1: IFU read, minimum latency
        ifu_req_valid = 1'b1;
        ifu_req_addr = 32'h8000_0000;
        s_req_ready = 1'b1;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'hDEAD_BEEF;
        ifu_resp_ready = 1'b1;
        #1;
        chk("t1_c0_ifu_req_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t1_c1_s_req_valid", s_req_valid, 1);
        chk("t1_c1_s_req_addr", s_req_addr, 32'h8000_0000);
        chk("t1_c1_s_req_wmask", s_req_wmask, 8'h00);
        tick();
        chk("t1_c2_s_resp_ready", s_resp_ready, 1);
        tick();
        chk("t1_c3_ifu_resp_valid", ifu_resp_valid, 1);
        chk("t1_c3_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("t1_c3_err", resp_err, 0);
        tick();
        chk("t1_c4_idle", ifu_resp_valid, 0);
        s_req_ready = 1'b0;
        s_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;

        // 2: LSU write held in REQ for 5 cycles
        lsu_req_valid = 1'b1;
        lsu_req_addr = 32'h8000_0010;
        lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'h1234_5678;
        lsu_req_wmask = 8'h0F;
        #1;
        chk("t2_lsu_req_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_req_addr = '0;
        lsu_req_wen = 1'b0;
        lsu_req_wdata = '0;
        lsu_req_wmask = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_s_req_addr", s_req_addr, 32'h8000_0010);
            chk("t2_s_req_wdata", s_req_wdata, 32'h1234_5678);
            chk("t2_s_req_wmask", s_req_wmask, 8'h0F);
            chk("t2_s_req_wen", s_req_wen, 1);
            tick();
        end
        s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_rdata = '0;
        lsu_resp_ready = 1'b1;
        tick();
        chk("t2_lsu_resp_valid", lsu_resp_valid, 1);
        chk("t2_ifu_resp_valid", ifu_resp_valid, 0);
        s_resp_valid = 1'b0;
        tick();
        lsu_resp_ready = 1'b0;

        // 3: simultaneous requests three times after a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
`ifdef ARB_RR_EN
        exp3 = 3'b101;
`else
        exp3 = 3'b111;
`endif
        for (int i = 0; i < 3; i++) begin
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            ifu_req_addr = 32'h1000 + i;
            lsu_req_addr = 32'h2000 + i;
            #1;
            chk("t3_lsu_req_ready", lsu_req_ready, exp3[i]);
            chk("t3_ifu_req_ready", ifu_req_ready, !exp3[i]);
            tick();
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            complete("t3", exp3[i], 32'h3000 + i);
        end

        // 4: hung slave times out after TO cycles in RESP
        ifu_req_valid = 1'b1;
        ifu_req_addr = 32'h200;
        tick();
        ifu_req_valid = 1'b0;
        s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0;
        n = 0;
        while (!ifu_resp_valid && n < 30) begin
            tick();
            n++;
        end
        chk("t4_latency", n, TO);
        chk("t4_err", resp_err, 1);
        chk("t4_rdata", resp_rdata, 0);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h55;
        #1;
        chk("t4_late_s_resp_ready", s_resp_ready, 0);
        tick();
        chk("t4_late_resp_valid", ifu_resp_valid, 0);
        chk("t4_late_s_req_valid", s_req_valid, 0);
        chk("t4_late_rdata", resp_rdata, 0);
        chk("t4_late_err", resp_err, 1);
        s_resp_valid = 1'b0;

        // 4b: response in the expiry cycle wins
        ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0;
        repeat (TO - 1) tick();
        chk("t4b_not_yet", ifu_resp_valid, 0);
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'hCAFE_F00D;
        tick();
        chk("t4b_resp_valid", ifu_resp_valid, 1);
        chk("t4b_err", resp_err, 0);
        chk("t4b_rdata", resp_rdata, 32'hCAFE_F00D);
        s_resp_valid = 1'b0;
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;

        // 5: asynchronous reset in RESP, then a normal transaction
        ifu_req_valid = 1'b1;
        ifu_req_addr = 32'h300;
        tick();
        ifu_req_valid = 1'b0;
        s_req_ready = 1'b1;
        tick();
        s_req_ready = 1'b0;
        tick();
        ifu_req_valid = 1'b1;
        #2;
        rst = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'hBAD;
        #1;
        chk("t5_s_req_valid", s_req_valid, 0);
        chk("t5_s_resp_ready", s_resp_ready, 0);
        chk("t5_ifu_req_ready", ifu_req_ready, 0);
        chk("t5_lsu_req_ready", lsu_req_ready, 0);
        chk("t5_ifu_resp_valid", ifu_resp_valid, 0);
        chk("t5_lsu_resp_valid", lsu_resp_valid, 0);
        chk("t5_rdata", resp_rdata, 0);
        chk("t5_err", resp_err, 0);
        chk("t5_s_req_addr", s_req_addr, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_after_ifu_req_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        complete("t5", 1'b0, 32'h600D_600D);

        // 6: DONE stalled while the other master waits
        lsu_req_valid = 1'b1;
        lsu_req_addr = 32'h40;
        lsu_req_wen = 1'b0;
        tick();
        lsu_req_valid = 1'b0;
        s_req_ready = 1'b1;
        s_resp_valid = 1'b1;
        s_resp_rdata = 32'h7777;
        tick();
        tick();
        s_req_ready = 1'b0;
        s_resp_valid = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t6_lsu_resp_valid", lsu_resp_valid, 1);
            chk("t6_rdata", resp_rdata, 32'h7777);
            chk("t6_ifu_req_ready", ifu_req_ready, 0);
            tick();
        end
        lsu_resp_ready = 1'b1;
        tick();
        lsu_resp_ready = 1'b0;
        chk("t6_ifu_req_ready_after", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        complete("t6", 1'b0, 32'h8888);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the single data-memory port between IFU (instruction fetch, read-only) and LSU (load/store, read/write). Keeps at most one transaction in flight. Registers the slave response and returns it to the granted master over a valid/ready handshake. A timeout counter converts a hung slave into an error response so the pipeline never deadlocks.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles in RESP before a forced error response; counter width $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset (0 = reset)
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_W  IFU read address
ifu_resp_valid  out  1  response for IFU valid
ifu_resp_ready  in  1  IFU takes response
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_W  LSU address
lsu_req_wen  in  1  1 = write, 0 = read
lsu_req_wdata  in  DATA_W  write data
lsu_req_wmask  in  8  byte write mask
lsu_resp_valid  out  1  response for LSU valid
lsu_resp_ready  in  1  LSU takes response
resp_rdata  out  DATA_W  shared response data, qualified by ifu/lsu_resp_valid
resp_err  out  1  shared response error flag (timeout)
s_req_valid  out  1  request to memory
s_req_ready  in  1  memory accepts request
s_req_addr  out  ADDR_W  latched address
s_req_wen  out  1  latched write enable
s_req_wdata  out  DATA_W  latched write data
s_req_wmask  out  8  latched mask; 8'h00 for IFU requests
s_resp_valid  in  1  memory response valid
s_resp_ready  out  1  arbiter takes memory response
s_resp_rdata  in  DATA_W  memory read data (don't-care for writes)

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset (rst=0, asynchronous): state IDLE, grant=IFU, rr pointer favours LSU, timeout count 0, all outputs 0, latched request and response registers 0.
- IDLE: xxx_req_ready=1 only for the master picked this cycle (combinational). Pick is qualified by the requesting valid. On handshake: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and grant, go REQ. No request: stay IDLE.
- Default pick: LSU over IFU, fixed priority.
- REQ: s_req_valid=1, s_req_* driven from latches and held stable. On s_req_ready=1: go RESP, clear timeout count.
- RESP: s_resp_ready=1. On s_resp_valid: latch rdata, err=0, go DONE.
  - Otherwise count+1. When count==TIMEOUT with no s_resp_valid: rdata=0, err=1, go DONE.
  - s_resp_valid arriving in the same cycle as expiry wins (err=0).
- DONE: granted master's resp_valid=1; resp_rdata/resp_err held stable. On its resp_ready: go IDLE. New requests are accepted only from IDLE.
- Minimum latency: request accepted at cycle 0, s_req_valid at cycle 1, response at cycle 2 (slave ready and responding in one cycle each), resp_valid at cycle 3, IDLE at cycle 4. Back-to-back throughput: 1 transaction per 4 cycles.
- s_resp_valid outside RESP is ignored (s_resp_ready=0). Applies to stale responses after reset.
- Reset mid-transaction: abort immediately to IDLE, outputs 0. The in-flight slave transaction is dropped.
- Master drops req_valid before handshake: legal; nothing latched.
- Stall: resp_ready=0 holds DONE indefinitely. The other master waits.

Optional Feature:
ARB_RR_EN:
- Defined: 2-way round-robin. A 1-bit pointer is updated on every request handshake to favour the master not just granted. On conflict the favoured master wins; a lone requester always wins.
- Undefined: fixed priority LSU > IFU, no pointer register.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE=2'd0, REQ=2'd1, RESP=2'd2, DONE=2'd3)
  - master ids (MST_IFU=1'b0, MST_LSU=1'b1)
  - default TIMEOUT constant
- Sub-module arb_pick2: combinational 2-way picker. Inputs req[1:0], pointer; outputs one-hot grant. Contains the ARB_RR_EN pointer register with clk/rst.

Test Plan:
1. IFU read of 0x8000_0000; slave ready immediately and returns 0xDEADBEEF next cycle -> ifu_resp_valid at cycle 3, resp_rdata=0xDEADBEEF, err=0, s_req_wmask=0x00.
2. LSU write addr 0x8000_0010, wdata 0x1234_5678, wmask 0x0F -> s_req_* match exactly and stay stable while s_req_ready held 0 for 5 cycles; lsu_resp_valid follows the response.
3. IFU and LSU request in the same cycle, three times in a row:
   - Without ARB_RR_EN: LSU granted all three.
   - With ARB_RR_EN: grants LSU, IFU, LSU.
4. Slave accepts a request and never responds, TIMEOUT=8 -> resp_valid exactly 8 cycles after entering RESP with err=1, rdata=0; a late s_resp_valid in IDLE is ignored.
5. rst pulled low during RESP -> all outputs 0 asynchronously. After release, a new IFU request completes normally.
6. resp_ready held 0 for 10 cycles in DONE while the other master requests -> rdata stable, no req_ready to the other master until DONE exits.
